// File: rtl/spi_tx16_if.sv
// -----------------------------------------------------------------------------
// spi_tx16_if -- request/status bundle for the 16-bit SPI word transmitter.
//   start : transfer request, sampled on the clk rising edge (master -> slave)
//   addr  : 2-bit word address, captured when start is accepted
//   data  : 16-bit word to send, captured when start is accepted
//   busy  : high while a transfer is in progress (slave -> master)
//   done  : one-cycle completion pulse (slave -> master)
// -----------------------------------------------------------------------------
interface spi_tx16_if;
    logic        start;
    logic [1:0]  addr;
    logic [15:0] data;
    logic        busy;
    logic        done;

    modport master (output start, output addr, output data, input busy, input done);
    modport slave  (input start, input addr, input data, output busy, output done);
endinterface

// File: rtl/spi_tx16.sv
// -----------------------------------------------------------------------------
// spi_tx16 -- serialises one 16-bit word MSB first over a write-only SPI link,
// with a 2-bit word address presented in parallel on spi_a.
//   clk      : system clock, all state updates on the rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : start/addr/data request, busy/done status (spi_tx16_if.slave)
//   spi_cs   : chip select, active-low
//   spi_clk  : serial clock, idles high; receiver samples on its rising edge
//   spi_mosi : serial data, changes only while spi_clk is high
//   spi_a    : word address, held from acceptance until the next accepted start
// Every phase (SETUP, CS_LOW, 16 x BIT_HI/BIT_LO, END) lasts CLK_DIV clocks,
// so a transfer keeps busy high for exactly 35*CLK_DIV cycles.
// -----------------------------------------------------------------------------
module spi_tx16 #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    spi_tx16_if.slave  bus,
    output logic       spi_cs,
    output logic       spi_clk,
    output logic       spi_mosi,
    output logic [1:0] spi_a
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_CS_LOW = 3'd2,
        ST_BIT_HI = 3'd3,
        ST_BIT_LO = 3'd4,
        ST_END    = 3'd5
    } state_t;

    // Phase timer reload: the counter runs CLK_DIV-1 down to 0.
    localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);

    state_t      state_r, state_s;
    logic [7:0]  cnt_r,   cnt_s;
    logic [3:0]  bit_r,   bit_s;
    logic [15:0] data_r,  data_s;
    logic        cs_r,    cs_s;
    logic        sclk_r,  sclk_s;
    logic        mosi_r,  mosi_s;
    logic [1:0]  a_r,     a_s;
    logic        busy_r,  busy_s;
    logic        done_r,  done_s;

    // Next-state and next-output logic; every SPI pin value is decided here
    // one cycle ahead so the pins themselves come straight from flops.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        bit_s   = bit_r;
        data_s  = data_r;
        cs_s    = cs_r;
        sclk_s  = sclk_r;
        mosi_s  = mosi_r;
        a_s     = a_r;
        busy_s  = busy_r;
        done_s  = 1'b0;

        if (state_r == ST_IDLE) begin
            // Accepting in IDLE also covers the done cycle, which is IDLE.
            if (bus.start) begin
                state_s = ST_SETUP;
                cnt_s   = DIV_LOAD;
                data_s  = bus.data;
                a_s     = bus.addr;
                busy_s  = 1'b1;
                cs_s    = 1'b1;
                sclk_s  = 1'b1;
                mosi_s  = 1'b0;
            end else begin
                state_s = ST_IDLE;
            end
        end else if (cnt_r != 8'd0) begin
            cnt_s = cnt_r - 8'd1;
        end else begin
            cnt_s = DIV_LOAD;
            case (state_r)
                ST_SETUP: begin
                    state_s = ST_CS_LOW;
                    cs_s    = 1'b0;
                    bit_s   = 4'd15;
                    mosi_s  = data_r[15];
                end
                ST_CS_LOW: begin
                    state_s = ST_BIT_HI;
                    mosi_s  = data_r[bit_r];
                end
                ST_BIT_HI: begin
                    state_s = ST_BIT_LO;
                    sclk_s  = 1'b0;
                end
                ST_BIT_LO: begin
                    // This rising edge is the receiver's sampling edge for bit_r;
                    // the next bit is launched on the same edge.
                    sclk_s = 1'b1;
                    if (bit_r == 4'd0) begin
                        state_s = ST_END;
                    end else begin
                        state_s = ST_BIT_HI;
                        bit_s   = bit_r - 4'd1;
                        mosi_s  = data_r[bit_s];
                    end
                end
                ST_END: begin
                    state_s = ST_IDLE;
                    cnt_s   = 8'd0;
                    cs_s    = 1'b1;
                    mosi_s  = 1'b0;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = 8'd0;
                    cs_s    = 1'b1;
                    sclk_s  = 1'b1;
                    mosi_s  = 1'b0;
                    busy_s  = 1'b0;
                end
            endcase
        end
    end

    // State, timer, latched word and all output flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 8'd0;
            bit_r   <= 4'd0;
            data_r  <= 16'd0;
            cs_r    <= 1'b1;
            sclk_r  <= 1'b1;
            mosi_r  <= 1'b0;
            a_r     <= 2'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            bit_r   <= bit_s;
            data_r  <= data_s;
            cs_r    <= cs_s;
            sclk_r  <= sclk_s;
            mosi_r  <= mosi_s;
            a_r     <= a_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign spi_cs   = cs_r;
    assign spi_clk  = sclk_r;
    assign spi_mosi = mosi_r;
    assign spi_a    = a_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;

endmodule

// File: tb/tb_spi_tx16.sv
// -----------------------------------------------------------------------------
// tb_spi_tx16 -- directed bench for spi_tx16. dut2 runs with CLK_DIV=2 and
// dut1 with CLK_DIV=1. A monitor acts as the SPI receiver: it shifts in
// spi_mosi on each spi_clk rise while spi_cs is low, counts busy cycles and
// records one word per done pulse for the stimulus thread to compare.
// -----------------------------------------------------------------------------
module tb_spi_tx16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    spi_tx16_if bus2 ();
    spi_tx16_if bus1 ();

    logic       cs2, sclk2, mosi2;
    logic [1:0] a2;
    logic       cs1, sclk1, mosi1;
    logic [1:0] a1;

    spi_tx16 #(.CLK_DIV(2)) dut2 (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus2.slave),
        .spi_cs   (cs2),
        .spi_clk  (sclk2),
        .spi_mosi (mosi2),
        .spi_a    (a2)
    );

    spi_tx16 #(.CLK_DIV(1)) dut1 (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus1.slave),
        .spi_cs   (cs1),
        .spi_clk  (sclk1),
        .spi_mosi (mosi1),
        .spi_a    (a1)
    );

    typedef struct {
        logic [15:0] word;
        int          edges;
        int          busy_cyc;
        int          viol;
        int          gap;
        logic [1:0]  a_fall;
        int          done_bad;
    } rec_t;

    rec_t q2[$];
    rec_t q1[$];

    int n_tests = 0;
    int n_fail  = 0;

    int done_total2 = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Receiver model for both DUTs, sampling on the falling clk edge.
    initial begin : monitor
        logic [15:0] cap2, cap1;
        int          edges2, busy2, viol2, gap2, acc2, done_bad2;
        int          edges1, busy1;
        logic [1:0]  afall2;
        logic        p_sclk2, p_mosi2, p_cs2, p_busy2;
        logic        p_sclk1, p_mosi1;
        int          cyc;
        rec_t        r;
        cap2 = 16'd0; cap1 = 16'd0;
        edges2 = 0; busy2 = 0; viol2 = 0; gap2 = 0; acc2 = 0; done_bad2 = 0;
        edges1 = 0; busy1 = 0; afall2 = 2'd0; cyc = 0;
        p_sclk2 = 1'b1; p_mosi2 = 1'b0; p_cs2 = 1'b1; p_busy2 = 1'b0;
        p_sclk1 = 1'b1; p_mosi1 = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                cap2 = 16'd0; edges2 = 0; busy2 = 0; viol2 = 0; done_bad2 = 0;
                cap1 = 16'd0; edges1 = 0; busy1 = 0;
                p_sclk2 = 1'b1; p_mosi2 = 1'b0; p_cs2 = 1'b1; p_busy2 = 1'b0;
                p_sclk1 = 1'b1; p_mosi1 = 1'b0;
            end else begin
                cyc = cyc + 1;
                // dut2
                if (bus2.busy) busy2 = busy2 + 1;
                if (bus2.busy && !p_busy2) acc2 = cyc;
                if (p_cs2 && !cs2) begin
                    gap2   = cyc - acc2;
                    afall2 = a2;
                end
                if ((mosi2 != p_mosi2) && !sclk2) viol2 = viol2 + 1;
                if (!p_sclk2 && sclk2 && !cs2) begin
                    cap2   = {cap2[14:0], p_mosi2};
                    edges2 = edges2 + 1;
                end
                if (bus2.done) begin
                    if (bus2.busy || !cs2) done_bad2 = done_bad2 + 1;
                    done_total2 = done_total2 + 1;
                    r.word = cap2; r.edges = edges2; r.busy_cyc = busy2; r.viol = viol2;
                    r.gap = gap2; r.a_fall = afall2; r.done_bad = done_bad2;
                    q2.push_back(r);
                    cap2 = 16'd0; edges2 = 0; busy2 = 0; viol2 = 0; done_bad2 = 0;
                end
                p_sclk2 = sclk2; p_mosi2 = mosi2; p_cs2 = cs2; p_busy2 = bus2.busy;
                // dut1
                if (bus1.busy) busy1 = busy1 + 1;
                if (!p_sclk1 && sclk1 && !cs1) begin
                    cap1   = {cap1[14:0], p_mosi1};
                    edges1 = edges1 + 1;
                end
                if (bus1.done) begin
                    r.word = cap1; r.edges = edges1; r.busy_cyc = busy1; r.viol = 0;
                    r.gap = 0; r.a_fall = a1; r.done_bad = 0;
                    q1.push_back(r);
                    cap1 = 16'd0; edges1 = 0; busy1 = 0;
                end
                p_sclk1 = sclk1; p_mosi1 = mosi1;
            end
        end
    end

    task automatic wait_done(input int sel);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ((sel == 2) ? bus2.done : bus1.done) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_timeout", {31'd0, seen}, 32'd1);
    endtask

    task automatic send2(input logic [1:0] a, input logic [15:0] d);
        @(negedge clk);
        bus2.start = 1'b1; bus2.addr = a; bus2.data = d;
        @(negedge clk);
        bus2.start = 1'b0;
        wait_done(2);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_rec2(input logic [15:0] w, input logic [1:0] a);
        rec_t r;
        check("rec2_avail", {31'd0, q2.size() > 0}, 32'd1);
        if (q2.size() > 0) begin
            r = q2.pop_front();
            check("word2",     r.word,     w);
            check("edges2",    r.edges,    16);
            check("busy2_cyc", r.busy_cyc, 70);
            check("mosi_viol", r.viol,     0);
            check("a_setup",   r.gap,      2);
            check("a_at_csf",  r.a_fall,   a);
            check("done_qual", r.done_bad, 0);
        end
    endtask

    initial begin : stim
        int   done_before;
        rec_t r;
        bus2.start = 1'b0; bus2.addr = 2'd0; bus2.data = 16'd0;
        bus1.start = 1'b0; bus1.addr = 2'd0; bus1.data = 16'd0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 check("rst_outs2", {cs2, sclk2, mosi2, a2, bus2.busy, bus2.done}, 7'b1100000);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_outs2", {cs2, sclk2, mosi2, a2, bus2.busy, bus2.done}, 7'b1100000);
        check("idle_outs1", {cs1, sclk1, mosi1, a1, bus1.busy, bus1.done}, 7'b1100000);

        // Single-bit word, LSB set.
        send2(2'b01, 16'h0001);
        check_rec2(16'h0001, 2'b01);
        check("a_hold_1", a2, 2'b01);

        // Alternating pattern, MSB 0.
        send2(2'b00, 16'h5555);
        check_rec2(16'h5555, 2'b00);
        check("a_hold_2", a2, 2'b00);

        // start held high across a transfer; data changed mid-word.
        @(negedge clk);
        bus2.start = 1'b1; bus2.addr = 2'b11; bus2.data = 16'h1000;
        @(negedge clk);
        bus2.data = 16'h1001;
        wait_done(2);
        @(negedge clk);
        check("b2b_accept", bus2.busy, 1);
        bus2.start = 1'b0;
        wait_done(2);
        repeat (3) @(negedge clk);
        check_rec2(16'h1000, 2'b11);
        check_rec2(16'h1001, 2'b11);

        // Reset during bit 8 aborts without done.
        done_before = done_total2;
        @(negedge clk);
        bus2.start = 1'b1; bus2.addr = 2'b10; bus2.data = 16'h0004;
        @(negedge clk);
        bus2.start = 1'b0;
        repeat (33) @(negedge clk);
        check("mid_cs_low", {cs2, sclk2, bus2.busy}, 3'b011);
        #2 reset_n = 1'b0;
        #1 check("abort_outs", {cs2, sclk2, mosi2, a2, bus2.busy, bus2.done}, 7'b1100000);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check("no_done_abort", done_total2, done_before);
        send2(2'b10, 16'h0004);
        check_rec2(16'h0004, 2'b10);
        check("a_hold_3", a2, 2'b10);

        // CLK_DIV=1 all-ones word.
        @(negedge clk);
        bus1.start = 1'b1; bus1.addr = 2'b01; bus1.data = 16'hFFFF;
        @(negedge clk);
        bus1.start = 1'b0;
        wait_done(1);
        repeat (3) @(negedge clk);
        check("rec1_avail", {31'd0, q1.size() > 0}, 32'd1);
        if (q1.size() > 0) begin
            r = q1.pop_front();
            check("word1",     r.word,     16'hFFFF);
            check("edges1",    r.edges,    16);
            check("busy1_cyc", r.busy_cyc, 35);
        end
        check("a_hold_d1", a1, 2'b01);
        check("end_idle1", {cs1, sclk1, mosi1, bus1.busy, bus1.done}, 5'b11000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_tx16.md
SPI_TX16 -- requirements
Module: spi_tx16

Interface
REQ-001 Parameter: CLK_DIV, default 2, SPI half-period in clk cycles; legal range 1..255.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  transfer request; sampled on clk rising edge.
REQ-005 addr  input  2  word address; captured when start is accepted.
REQ-006 data  input  16  word to send; captured when start is accepted.
REQ-007 busy  output  1  high while a transfer is in progress.
REQ-008 done  output  1  one-cycle pulse marking transfer completion.
REQ-009 spi_cs  output  1  chip select, active-low.
REQ-010 spi_clk  output  1  serial clock; idles high.
REQ-011 spi_mosi  output  1  serial data, MSB first.
REQ-012 spi_a  output  2  word address presented to the receiver.

Function
REQ-013 A start is accepted only on a clk edge where busy=0; start while busy=1 SHALL be ignored with no effect on the transfer in progress.
REQ-014 On acceptance: data and addr latched; spi_a<=addr; busy<=1 on the same edge.
REQ-015 spi_a SHALL remain stable from acceptance until the next accepted start, including after done.
REQ-016 FSM states: IDLE, SETUP, CS_LOW, BIT_HI, BIT_LO, END; each non-IDLE state lasts exactly CLK_DIV cycles, timed by an 8-bit down-counter.
REQ-017 SETUP: spi_cs=1, spi_clk=1; lets spi_a settle before select.
REQ-018 CS_LOW: spi_cs=0, spi_clk=1, spi_mosi=data[15].
REQ-019 BIT_HI for bit i (15 down to 0): spi_clk=1, spi_mosi=data[i]; spi_mosi SHALL change only on entry to BIT_HI.
REQ-020 BIT_LO for bit i: spi_clk=0, spi_mosi holds data[i]; exit to BIT_HI of bit i-1, or to END after bit 0.
REQ-021 The spi_clk rising edge at BIT_LO exit is the receiver sampling edge; exactly 16 rising edges SHALL occur while spi_cs=0.
REQ-022 END: spi_clk=1, spi_cs=0, spi_mosi holds data[0]; on exit spi_cs<=1, busy<=0, done<=1, state IDLE.
REQ-023 busy SHALL be high for exactly 35*CLK_DIV cycles per transfer.
REQ-024 done SHALL be high for exactly one cycle, coincident with the first cycle of busy=0 and spi_cs=1.
REQ-025 A start asserted during the done cycle SHALL be accepted (back-to-back transfers; SETUP guarantees spi_cs high for at least CLK_DIV cycles between words).
REQ-026 In IDLE: spi_cs=1, spi_clk=1, spi_mosi=0.
REQ-027 spi_cs, spi_clk, spi_mosi, spi_a SHALL be driven directly from flops (glitch-free).

Reset
REQ-028 reset_n=0 SHALL immediately force: spi_cs=1, spi_clk=1, spi_mosi=0, spi_a=0, busy=0, done=0, state IDLE, counters 0, latched data 0.
REQ-029 Reset mid-transfer SHALL abort without a done pulse; the receiver sees spi_cs rise with fewer than 16 clocks.
REQ-030 The first start SHALL be accepted no earlier than the first clk rising edge after reset_n deasserts.

Verification
REQ-031 Reset release, no start -> spi_cs=1, spi_clk=1, spi_mosi=0, spi_a=0, busy=0, done=0 held indefinitely.
REQ-032 CLK_DIV=2, start addr=2'b01 data=16'h0001 -> spi_a=01 two cycles before spi_cs falls; 16 bits captured on spi_clk rising edges = 0x0001; busy high 70 cycles; single done pulse.
REQ-033 addr=2'b00 data=16'h5555 -> captured 0x5555, MSB 0 first, spi_mosi transitions only while spi_clk=1.
REQ-034 start held high through a transfer with data=16'h1000, then data changed to 16'h1001 -> first word 0x1000 unaffected; second word 0x1001 begins with start accepted in the done cycle.
REQ-035 reset_n pulsed low during bit 8 of data=16'h0004 -> outputs at reset values immediately, no done; next start sends 0x0004 correctly.
REQ-036 CLK_DIV=1, data=16'hFFFF -> busy exactly 35 cycles, 16 spi_clk rising edges, captured 0xFFFF.
